// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory-stage access unit:
// access-size codes, FSM states and the lane mapping used by the bus.
package mem_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unsigned loads have no store counterpart, so they are illegal with a store.
    function automatic logic accessLegal(input logic [2:0] funct3,
                                         input logic [1:0] offset,
                                         input logic       isStore);
        case (funct3)
            F3_BYTE:  return 1'b1;
            F3_HALF:  return ~offset[0];
            F3_WORD:  return offset == 2'b00;
            F3_BYTEU: return ~isStore;
            F3_HALFU: return ~isStore & ~offset[0];
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byteEnables(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] replicateStore(input logic [2:0]        funct3,
                                                         input logic [DATA_W-1:0] data);
        case (funct3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a bus read word and sign- or zero-extends it
// to the full register width according to the load size.
module load_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_BYTE:  data = {{24{shifted[7]}}, shifted[7:0]};
            F3_HALF:  data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BYTEU: data = {24'b0, shifted[7:0]};
            F3_HALFU: data = {16'b0, shifted[15:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: checks alignment, issues one registered bus
// request per access, stalls the pipeline until ack or timeout, aligns loads.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              TimeoutM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [15:0]       reqCount;
    logic [2:0]        funct3Q;
    logic [1:0]        offsetQ;
    logic [DATA_W-1:0] loadData;
    logic              access;
    logic              legal;

    assign access = MemReadM | MemWriteM;
    assign legal  = accessLegal(Funct3M, ALUResultM[1:0], MemWriteM);

    // Stall starts in the detect cycle so the pipeline freezes before the bus answers.
    assign StallM    = (state == ST_REQ) | ((state == ST_IDLE) & access & legal);
    assign MisalignM = (state == ST_IDLE) & access & ~legal;

    load_align u_loadAlign (
        .rdata  (mem_rdata),
        .funct3 (funct3Q),
        .offset (offsetQ),
        .data   (loadData)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            reqCount  <= '0;
            funct3Q   <= '0;
            offsetQ   <= '0;
            ReadDataM <= '0;
            TimeoutM  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    reqCount <= '0;
                    if (access && legal) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= {ALUResultM[DATA_W-1:2], 2'b00};
                        mem_be    <= byteEnables(Funct3M, ALUResultM[1:0]);
                        mem_wdata <= replicateStore(Funct3M, WriteDataM);
                        funct3Q   <= Funct3M;
                        offsetQ   <= ALUResultM[1:0];
                        state     <= ST_REQ;
                    end else if (access) begin
                        ReadDataM <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            ReadDataM <= loadData;
                        end
                        mem_req <= 1'b0;
                        state   <= ST_DONE;
                    end else if (reqCount == TimeoutLast) begin
                        mem_req   <= 1'b0;
                        ReadDataM <= '0;
                        TimeoutM  <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        reqCount <= reqCount + 16'd1;
                    end
                end
                ST_DONE: begin
                    TimeoutM <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum REQ-state cycles without mem_ack before the access is abandoned (range 1..65535).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled only on rising edge of clk.
REQ-004 MemReadM  in  1  memory-stage instruction is a load.
REQ-005 MemWriteM  in  1  memory-stage instruction is a store.
REQ-006 Funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 ALUResultM  in  32  byte address.
REQ-008 WriteDataM  in  32  store data, right-aligned.
REQ-009 ReadDataM  out  32  extended load result, registered; feeds the MEM/WB register.
REQ-010 StallM  out  1  high while an access is outstanding; freezes F/D/E/M stages.
REQ-011 MisalignM  out  1  misaligned or illegal-size access present in M.
REQ-012 TimeoutM  out  1  current access abandoned on timeout.
REQ-013 mem_req, mem_we  out  1 each  bus request / write strobe, registered.
REQ-014 mem_addr  out  32  word address (ALUResultM with bits [1:0] forced to 00), registered.
REQ-015 mem_wdata  out  32  lane-replicated store data; mem_be  out  4  byte enables; both registered.
REQ-016 mem_ack  in  1  bus completion; mem_rdata  in  32  read word, valid with mem_ack.

Function
REQ-017 FSM states IDLE, REQ, DONE; reset and default state IDLE.
REQ-018 IDLE: if (MemReadM|MemWriteM) and access legal, latch bus outputs, assert StallM combinationally, go REQ; otherwise StallM=0 and stay IDLE.
REQ-019 MemReadM and MemWriteM both high: treated as a store.
REQ-020 Legality: byte any address; halfword needs addr[0]=0; word needs addr[1:0]=00; Funct3M 011/110/111 (and 100/101 with a store) illegal.
REQ-021 Illegal access: MisalignM=1 combinationally in IDLE, no bus request, no stall, ReadDataM loaded with 0 on that edge.
REQ-022 REQ: mem_req=1, StallM=1; mem_addr/mem_we/mem_be/mem_wdata held stable until exit.
REQ-023 REQ with mem_ack=1: load -> ReadDataM <= extended mem_rdata; mem_req drops on the same edge; go DONE.
REQ-024 REQ timeout counter counts cycles in REQ from 0; when it equals TIMEOUT_CYCLES-1 with no ack, drop mem_req, ReadDataM <= 0, set TimeoutM, go DONE.
REQ-025 DONE: StallM=0 so the pipeline advances exactly once; TimeoutM high only in this cycle; next state IDLE unconditionally.
REQ-026 Minimum stall: 2 cycles (IDLE detect, REQ with zero-wait ack); result visible in DONE cycle.
REQ-027 Byte enables: byte -> 4'b0001 << addr[1:0]; half -> 4'b0011 << addr[1:0]; word -> 4'b1111; loads drive the same enables.
REQ-028 Store data: byte replicated to all 4 lanes; halfword replicated to both halves; word unchanged.
REQ-029 Load extract: lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-030 mem_ack outside REQ is ignored.
REQ-031 ReadDataM holds its value in all cycles not listed in REQ-021/023/024.

Reset
REQ-032 reset=0 at a clock edge: state IDLE, counter 0, ReadDataM=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, TimeoutM=0; StallM=0 next cycle.
REQ-033 Reset during REQ abandons the access; a late mem_ack after reset is ignored.

Structure
REQ-034 Package mem_pkg holds Funct3 encodings, FSM state encoding, and the 32-bit data width constant.
REQ-035 One combinational sub-module load_align performs lane selection and sign/zero extension; the FSM, counter and bus registers live in mem_access_unit.

Verification
REQ-036 LW addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE, mem_be=1111.
REQ-037 SB addr 0x203, WriteDataM 0x000000A5 -> mem_addr 0x200, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
REQ-038 LH addr 0x102 rdata 0x80001234 -> ReadDataM=0xFFFF8000; LHU same -> 0x00008000.
REQ-039 LW addr 0x101 -> MisalignM=1, mem_req never asserted, StallM=0, ReadDataM=0.
REQ-040 TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, TimeoutM pulses 1 cycle, ReadDataM=0, back to IDLE.
REQ-041 reset low during REQ, then ack 1 cycle later -> mem_req=0, state IDLE, ReadDataM=0, ack ignored.
